// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle between the execute stage and alu_mc.
interface alu_mc_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             div0;
  logic             illegal;
  modport master (output in_valid, aluop, a, b, out_ready,
                  input  in_ready, out_valid, f, div0, illegal);
  modport slave  (input  in_valid, aluop, a, b, out_ready,
                  output in_ready, out_valid, f, div0, illegal);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit ALU with registered single-cycle ops and iterative MUL/DIVU/REMU,
// behind valid/ready handshakes so the pipeline can stall on long ops.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave io
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  state_e           state_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q, f_q;
  logic             rem_q, out_valid_q, div0_q, illegal_q;
  logic [WIDTH-1:0] alu_d, prod_d, rem_d, quo_d;
  logic [WIDTH:0]   rsh_d;
  logic [SHW-1:0]   sh;
  logic             ge_d, accept, hand, last, is_mul, is_long;
  assign sh           = io.b[SHW-1:0];
  assign io.in_ready  = (state_q == IDLE) && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && io.in_ready;
  assign hand         = out_valid_q && io.out_ready;
  assign last         = cnt_q == (SHW+1)'(1);
  assign is_mul       = io.aluop == 4'd11;
  assign is_long      = is_mul || io.aluop == 4'd12 || io.aluop == 4'd13;
  assign io.out_valid = out_valid_q;
  assign io.f         = f_q;
  assign io.div0      = div0_q;
  assign io.illegal   = illegal_q;
  always_comb begin
    alu_d = '0;
    case (io.aluop)
      4'd0:    alu_d = io.a + io.b;
      4'd1:    alu_d = io.a - io.b;
      4'd2:    alu_d = io.a & io.b;
      4'd3:    alu_d = io.a | io.b;
      4'd4:    alu_d = io.a ^ io.b;
      4'd5:    alu_d = ~(io.a & io.b);
      4'd6:    alu_d = ~io.a;
      4'd7:    alu_d = io.a;
      4'd8:    alu_d = io.a << sh;
      4'd9:    alu_d = io.a >> sh;
      4'd10:   alu_d = $unsigned($signed(io.a) >>> sh);
      default: alu_d = '0;
    endcase
  end
  // MUL: acc += mcand when the multiplier LSB is set; mcand shifts left, multiplier right.
  assign prod_d = acc_q + (y_q[0] ? x_q : '0);
  // DIV: restoring step; a zero divisor always "fits", giving all-ones quotient and remainder a.
  assign rsh_d  = {acc_q, y_q[WIDTH-1]};
  assign ge_d   = rsh_d >= {1'b0, x_q};
  assign rem_d  = ge_d ? WIDTH'(rsh_d - {1'b0, x_q}) : rsh_d[WIDTH-1:0];
  assign quo_d  = {y_q[WIDTH-2:0], ge_d};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      f_q         <= '0;
      rem_q       <= 1'b0;
      out_valid_q <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hand) out_valid_q <= 1'b0;
          if (accept && is_long) begin
            state_q <= is_mul ? MUL : DIV;
            cnt_q   <= (SHW+1)'(WIDTH);
            acc_q   <= '0;
            x_q     <= is_mul ? io.a : io.b;
            y_q     <= is_mul ? io.b : io.a;
            rem_q   <= io.aluop == 4'd13;
          end else if (accept) begin
            f_q         <= alu_d;
            out_valid_q <= 1'b1;
            div0_q      <= 1'b0;
            illegal_q   <= io.aluop[3:1] == 3'b111;
          end
        end
        MUL: begin
          acc_q <= prod_d;
          x_q   <= x_q << 1;
          y_q   <= y_q >> 1;
          cnt_q <= cnt_q - (SHW+1)'(1);
          if (last) begin
            state_q     <= IDLE;
            f_q         <= prod_d;
            out_valid_q <= 1'b1;
            div0_q      <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        DIV: begin
          acc_q <= rem_d;
          y_q   <= quo_d;
          cnt_q <= cnt_q - (SHW+1)'(1);
          if (last) begin
            state_q     <= IDLE;
            f_q         <= rem_q ? rem_d : quo_d;
            out_valid_q <= 1'b1;
            div0_q      <= x_q == '0;
            illegal_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc (WIDTH=16) with immediate assertions
// and a short random stream of single-cycle ops against a reference function.
module tb_alu_mc;
  logic clk, reset;
  int   errors = 0;
  int   checks = 0;
  int   bad, lat;
  logic [3:0]  op;
  logic [15:0] ra, rb, exp_f;
  alu_mc_if #(.WIDTH(16)) io ();
  alu_mc #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    io.in_valid = 1'b1;
    io.aluop    = o;
    io.a        = x;
    io.b        = y;
  endtask
  task automatic run_long(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int l);
    drive(o, x, y);
    tick;
    io.in_valid = 1'b0;
    l = 0;
    do begin
      tick;
      l++;
    end while (!io.out_valid && l < 40);
  endtask
  function automatic logic [15:0] model(input logic [3:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [3:0] s;
    s = y[3:0];
    case (o)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return ~(x & y);
      4'd6:    return ~x;
      4'd7:    return x;
      4'd8:    return x << s;
      4'd9:    return x >> s;
      4'd10:   return (x >> s) | (x[15] ? ~(16'hFFFF >> s) : 16'h0000);
      default: return 16'h0000;
    endcase
  endfunction
  initial begin
    reset = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.aluop = 4'd0;
    io.a = '0;
    io.b = '0;
    tick;
    tick;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_f", io.f, 0);
    chk("rst_flags", {io.div0, io.illegal}, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", io.in_ready, 1);
    drive(4'd0, 16'hFFFF, 16'h0001);
    tick;
    chk("add_wrap_valid", io.out_valid, 1);
    chk("add_wrap_f", io.f, 16'h0000);
    drive(4'd10, 16'h8000, 16'h0013);
    tick;
    chk("sra_f", io.f, 16'hF000);
    drive(4'd11, 16'h0123, 16'h0045);
    tick;
    chk("mul_busy_ready", io.in_ready, 0);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      drive(4'd0, 16'h1111, 16'h2222);
      io.in_valid = i[0];
      tick;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0) bad++;
    end
    io.in_valid = 1'b0;
    chk("mul_busy_cycles", bad, 0);
    tick;
    chk("mul_latency_valid", io.out_valid, 1);
    chk("mul_f", io.f, 16'h4E6F);
    tick;
    chk("mul_handoff", io.out_valid, 0);
    run_long(4'd11, 16'hFFFF, 16'hFFFF, lat);
    chk("mul_ffff_lat", lat, 16);
    chk("mul_ffff_f", io.f, 16'h0001);
    run_long(4'd12, 16'h1234, 16'h0007, lat);
    chk("divu_lat", lat, 16);
    chk("divu_f", io.f, 16'h0299);
    chk("divu_div0", io.div0, 0);
    run_long(4'd13, 16'h1234, 16'h0007, lat);
    chk("remu_f", io.f, 16'h0005);
    run_long(4'd12, 16'h1234, 16'h0000, lat);
    chk("divu0_lat", lat, 16);
    chk("divu0_f", io.f, 16'hFFFF);
    chk("divu0_flag", io.div0, 1);
    run_long(4'd13, 16'h1234, 16'h0000, lat);
    chk("remu0_f", io.f, 16'h1234);
    chk("remu0_flag", io.div0, 1);
    io.out_ready = 1'b0;
    tick;
    chk("div0_hold_ready", io.in_ready, 0);
    io.out_ready = 1'b1;
    drive(4'd2, 16'hF0F0, 16'h3CC3);
    #1;
    chk("and_accept_ready", io.in_ready, 1);
    tick;
    chk("and_f", io.f, 16'h30C0);
    chk("and_clears_div0", io.div0, 0);
    io.out_ready = 1'b0;
    drive(4'd3, 16'hF0F0, 16'h0F0F);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (io.in_ready !== 1'b0) bad++;
      tick;
      if (io.f !== 16'h30C0 || io.out_valid !== 1'b1) bad++;
    end
    chk("backpressure_hold", bad, 0);
    io.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", io.in_ready, 1);
    tick;
    io.in_valid = 1'b0;
    chk("or_valid", io.out_valid, 1);
    chk("or_f", io.f, 16'hFFFF);
    tick;
    chk("or_single", io.out_valid, 0);
    drive(4'd12, 16'h1234, 16'h0007);
    tick;
    io.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", io.out_valid, 0);
    chk("async_rst_f", io.f, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", io.in_ready, 1);
    drive(4'd0, 16'h0002, 16'h0003);
    tick;
    io.in_valid = 1'b0;
    chk("post_rst_add_valid", io.out_valid, 1);
    chk("post_rst_add_f", io.f, 16'h0005);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (io.out_valid !== 1'b0) bad++;
    end
    chk("no_stale_div", bad, 0);
    drive(4'd14, 16'h1234, 16'h5678);
    tick;
    chk("op14_f", io.f, 0);
    chk("op14_illegal", io.illegal, 1);
    drive(4'd15, 16'hFFFF, 16'hFFFF);
    tick;
    chk("op15_illegal", {io.out_valid, io.illegal, io.f}, {2'b11, 16'h0000});
    drive(4'd0, 16'h0100, 16'h0023);
    tick;
    chk("add_clears_illegal", io.illegal, 0);
    chk("add_after_illegal_f", io.f, 16'h0123);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      op = 4'($urandom_range(0, 10));
      ra = 16'($urandom);
      rb = 16'($urandom);
      exp_f = model(op, ra, rb);
      drive(op, ra, rb);
      #1;
      if (io.in_ready !== 1'b1) bad++;
      tick;
      chk("stream_f", {io.out_valid, io.f}, {1'b1, exp_f});
    end
    io.in_valid = 1'b0;
    chk("stream_ready", bad, 0);
    tick;
    chk("stream_drain", io.out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
